vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch in pixels
- H_SYNC, 120, horizontal sync width in pixels
- H_BP, 64, horizontal back porch in pixels
- V_ACTIVE, 600, visible lines
- V_FP, 37, vertical front porch in lines
- V_SYNC, 6, vertical sync width in lines
- V_BP, 23, vertical back porch in lines
- H_POL, 0, asserted level of hSync (0 = active-low)
- V_POL, 0, asserted level of vSync
- PIPE, 2, pixel-strobe delay on sync/blank outputs (legal 0..4)
- XW, 11, x counter width
- YW, 10, y counter width

REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- Clock, in, 1, system clock; sole clock
- Reset_n, in, 1, asynchronous active-low reset
- pixEn, in, 1, pixel strobe; all counting and delay stages advance only when high
- hSync, out, 1, horizontal sync at H_POL level when asserted
- vSync, out, 1, vertical sync at V_POL level when asserted
- blank_n, out, 1, 1 inside the visible area, 0 otherwise
- sync_n, out, 1, 0 when the horizontal or vertical sync region is active
- nextX, out, XW, hCount when hCount < H_ACTIVE, else 0
- nextY, out, YW, vCount when vCount < V_ACTIVE, else 0
- lineStart, out, 1, high when pixEn=1 and hCount=0
- frameStart, out, 1, high when pixEn=1 and hCount=0 and vCount=0
- frameCount, out, 8, frames completed, modulo 256

Function
REQ-003 Totals SHALL be H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP; H_TOT ≤ 2^XW and V_TOT ≤ 2^YW.
REQ-004 On a Clock edge with pixEn=1, hCount SHALL increment; at H_TOT-1 it SHALL wrap to 0.
REQ-005 vCount SHALL increment only on an hCount wrap; at V_TOT-1 with an hCount wrap it SHALL wrap to 0.
REQ-006 On a vCount wrap, frameCount SHALL increment, wrapping from 255 to 0.
REQ-007 With pixEn=0, the counters, frameCount and all delay stages SHALL hold their values.
REQ-008 Raw hSync region: H_ACTIVE+H_FP ≤ hCount < H_ACTIVE+H_FP+H_SYNC.
REQ-009 Raw vSync region: V_ACTIVE+V_FP ≤ vCount < V_ACTIVE+V_FP+V_SYNC.
REQ-010 Raw blank_n: hCount < H_ACTIVE and vCount < V_ACTIVE.
REQ-011 Raw sync_n SHALL be the NOR of the raw hSync and raw vSync region flags.
REQ-012 hSync, vSync, blank_n and sync_n SHALL be the raw values delayed by PIPE pixEn-qualified register stages; with PIPE=0 they SHALL be combinational from the counters.
REQ-013 nextX, nextY, lineStart and frameStart SHALL be undelayed, combinational from the registered counters and pixEn.
REQ-014 The hSync/vSync output level SHALL be the polarity parameter when the region is active, and its inverse otherwise.

Reset
REQ-015 Reset_n=0 SHALL asynchronously clear hCount, vCount and frameCount to 0.
REQ-016 Reset_n=0 SHALL load every delay stage with hSync/vSync deasserted, blank_n=0 and sync_n=1.
REQ-017 After release, the first PIPE pixEn strobes SHALL present the reset fill values on the delayed outputs.
REQ-018 Reset asserted mid-line or mid-frame SHALL take effect without waiting for a Clock edge.

Verification
REQ-019 Defaults, pixEn=1, PIPE=2 -> hSync=0 for exactly the 120 cycles in which hCount=858..977; blank_n=1 while hCount=2..801 on lines with vCount<600 (rows 2..1 wrap handled).
REQ-020 Defaults, pixEn toggling 1/0 -> line period 2080 Clocks; lineStart pulse width 1 Clock; nextX holds during pixEn=0 cycles.
REQ-021 Defaults, 692640 strobes from reset -> frameStart exactly once at strobe 692640; frameCount 0→1; 256 frames -> frameCount wraps to 0.
REQ-022 Reset_n pulsed low at hCount=500, vCount=300 -> all counters read 0 before the next Clock edge; blank_n=0 for 2 strobes after release.
REQ-023 Parameters H=4/1/2/1, V=3/1/1/1, H_POL=V_POL=1, PIPE=0 -> hSync=1 only at hCount 5..6; vSync=1 only at vCount=4; sync_n=0 exactly when either is active.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parameterised VGA raster timing generator: pixel/line counters, sync/blank
// regions with a pixEn-qualified output delay line, and a frame counter.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 56,
  parameter int   H_SYNC   = 120,
  parameter int   H_BP     = 64,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 37,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 23,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   PIPE     = 2,
  parameter int   XW       = 11,
  parameter int   YW       = 10
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          pixEn,
  output logic          hSync,
  output logic          vSync,
  output logic          blank_n,
  output logic          sync_n,
  output logic [XW-1:0] nextX,
  output logic [YW-1:0] nextY,
  output logic          lineStart,
  output logic          frameStart,
  output logic [7:0]    frameCount
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW1   = XW + 1;
  localparam int YW1   = YW + 1;

  // Region bounds are one bit wider than the counters so an end bound equal
  // to 2^XW (or 2^YW) is still representable.
  localparam logic [XW-1:0] H_LAST = XW'(H_TOT - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOT - 1);
  localparam logic [XW:0]   H_VIS  = XW1'(H_ACTIVE);
  localparam logic [XW:0]   HS_BEG = XW1'(H_ACTIVE + H_FP);
  localparam logic [XW:0]   HS_END = XW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW:0]   V_VIS  = YW1'(V_ACTIVE);
  localparam logic [YW:0]   VS_BEG = YW1'(V_ACTIVE + V_FP);
  localparam logic [YW:0]   VS_END = YW1'(V_ACTIVE + V_FP + V_SYNC);

  // Delay-line word layout: {hsync region, vsync region, blank_n, sync_n}.
  localparam logic [3:0] FILL = 4'b0001;

  logic [XW-1:0] h_count;
  logic [YW-1:0] v_count;
  logic [7:0]    frame_count;
  logic [XW:0]   h_ext;
  logic [YW:0]   v_ext;
  logic          h_region;
  logic          v_region;
  logic [3:0]    raw;
  logic [3:0]    dly;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      h_count     <= '0;
      v_count     <= '0;
      frame_count <= '0;
    end else if (pixEn) begin
      if (h_count == H_LAST) begin
        h_count <= '0;
        if (v_count == V_LAST) begin
          v_count     <= '0;
          frame_count <= frame_count + 8'd1;
        end else begin
          v_count <= v_count + 1'b1;
        end
      end else begin
        h_count <= h_count + 1'b1;
      end
    end
  end

  always_comb begin
    h_ext    = {1'b0, h_count};
    v_ext    = {1'b0, v_count};
    h_region = (h_ext >= HS_BEG) && (h_ext < HS_END);
    v_region = (v_ext >= VS_BEG) && (v_ext < VS_END);
    raw      = {h_region, v_region, (h_ext < H_VIS) && (v_ext < V_VIS), ~(h_region | v_region)};
  end

  generate
    if (PIPE == 0) begin : g_direct
      assign dly = raw;
    end else begin : g_pipe
      logic [3:0] stage [PIPE];

      always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
          for (int i = 0; i < PIPE; i++) stage[i] <= FILL;
        end else if (pixEn) begin
          stage[0] <= raw;
          for (int i = 1; i < PIPE; i++) stage[i] <= stage[i-1];
        end
      end

      assign dly = stage[PIPE-1];
    end
  endgenerate

  assign hSync      = dly[3] ? H_POL : ~H_POL;
  assign vSync      = dly[2] ? V_POL : ~V_POL;
  assign blank_n    = dly[1];
  assign sync_n     = dly[0];
  assign nextX      = (h_ext < H_VIS) ? h_count : '0;
  assign nextY      = (v_ext < V_VIS) ? v_count : '0;
  assign lineStart  = pixEn && (h_count == '0);
  assign frameStart = lineStart && (v_count == '0);
  assign frameCount = frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, tiny PIPE=0 with
// positive polarity, tiny PIPE=3) checked against a strobe-count reference model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        bn;
    logic        sn;
    logic [15:0] nx;
    logic [15:0] ny;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } exp_t;

  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb;
    bit hp, vp;
    int pipe;
  } cfg_t;

  typedef struct {
    int adv;
    bit en;
    bit hs, vs, sn, bn, ls, fs;
    int nx, ny, fc;
  } vec_t;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [2:0] rst_n;
  logic [2:0] pix_en;

  logic hsync0, vsync0, blank_n0, sync_n0, line_start0, frame_start0;
  logic [10:0] next_x0;
  logic [9:0]  next_y0;
  logic [7:0]  frame_count0;
  logic hsync1, vsync1, blank_n1, sync_n1, line_start1, frame_start1;
  logic [2:0]  next_x1, next_y1;
  logic [7:0]  frame_count1;
  logic hsync2, vsync2, blank_n2, sync_n2, line_start2, frame_start2;
  logic [2:0]  next_x2, next_y2;
  logic [7:0]  frame_count2;

  vga_timing_gen u_dut0 (
    .Clock(Clock), .Reset_n(rst_n[0]), .pixEn(pix_en[0]),
    .hSync(hsync0), .vSync(vsync0), .blank_n(blank_n0), .sync_n(sync_n0),
    .nextX(next_x0), .nextY(next_y0), .lineStart(line_start0),
    .frameStart(frame_start0), .frameCount(frame_count0)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .PIPE(0), .XW(3), .YW(3)
  ) u_dut1 (
    .Clock(Clock), .Reset_n(rst_n[1]), .pixEn(pix_en[1]),
    .hSync(hsync1), .vSync(vsync1), .blank_n(blank_n1), .sync_n(sync_n1),
    .nextX(next_x1), .nextY(next_y1), .lineStart(line_start1),
    .frameStart(frame_start1), .frameCount(frame_count1)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .PIPE(3), .XW(3), .YW(3)
  ) u_dut2 (
    .Clock(Clock), .Reset_n(rst_n[2]), .pixEn(pix_en[2]),
    .hSync(hsync2), .vSync(vsync2), .blank_n(blank_n2), .sync_n(sync_n2),
    .nextX(next_x2), .nextY(next_y2), .lineStart(line_start2),
    .frameStart(frame_start2), .frameCount(frame_count2)
  );

  cfg_t   cfg [3];
  vec_t   vecs [13];
  longint strobes [3];
  int     checks = 0;
  int     errors = 0;
  int     fs_count = 0;

  // Everything follows from n, the number of strobes since reset; the delayed
  // outputs show the raw region flags of strobe n-PIPE, or the reset fill.
  function automatic exp_t model(cfg_t c, longint n, bit en);
    exp_t   e;
    longint ht, vt, h, v, m, hm, vm;
    bit     hr, vr;
    e  = '0;
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    h  = n % ht;
    v  = (n / ht) % vt;
    e.nx = (h < c.ha) ? 16'(h) : 16'd0;
    e.ny = (v < c.va) ? 16'(v) : 16'd0;
    e.ls = en && (h == 0);
    e.fs = e.ls && (v == 0);
    e.fc = 8'((n / (ht * vt)) % 256);
    if (n < c.pipe) begin
      hr = 1'b0;
      vr = 1'b0;
      e.bn = 1'b0;
      e.sn = 1'b1;
    end else begin
      m  = n - c.pipe;
      hm = m % ht;
      vm = (m / ht) % vt;
      hr = (hm >= c.ha + c.hf) && (hm < c.ha + c.hf + c.hsw);
      vr = (vm >= c.va + c.vf) && (vm < c.va + c.vf + c.vsw);
      e.bn = (hm < c.ha) && (vm < c.va);
      e.sn = !(hr || vr);
    end
    e.hs = hr ? c.hp : !c.hp;
    e.vs = vr ? c.vp : !c.vp;
    return e;
  endfunction

  function automatic exp_t sample(int d);
    exp_t a;
    a = '0;
    case (d)
      0: begin
        a.hs = hsync0; a.vs = vsync0; a.bn = blank_n0; a.sn = sync_n0;
        a.nx = 16'(next_x0); a.ny = 16'(next_y0);
        a.ls = line_start0; a.fs = frame_start0; a.fc = frame_count0;
      end
      1: begin
        a.hs = hsync1; a.vs = vsync1; a.bn = blank_n1; a.sn = sync_n1;
        a.nx = 16'(next_x1); a.ny = 16'(next_y1);
        a.ls = line_start1; a.fs = frame_start1; a.fc = frame_count1;
      end
      default: begin
        a.hs = hsync2; a.vs = vsync2; a.bn = blank_n2; a.sn = sync_n2;
        a.nx = 16'(next_x2); a.ny = 16'(next_y2);
        a.ls = line_start2; a.fs = frame_start2; a.fc = frame_count2;
      end
    endcase
    return a;
  endfunction

  task automatic checkOutput(string name, int d, longint n, bit e);
    exp_t want, got;
    want = model(cfg[d], n, e);
    got  = sample(d);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s dut%0d strobe=%0d got=%h expected=%h", name, d, n, got, want);
    end
  endtask

  task automatic checkValue(string name, longint got, longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  task automatic applyStimulus(int d, bit e, string name);
    pix_en[d] = e;
    @(negedge Clock);
    checkOutput(name, d, strobes[d], e);
    if (d == 2 && frame_start2) fs_count++;
    @(posedge Clock);
    if (e) strobes[d]++;
    #1;
  endtask

  initial begin
    exp_t want, got;
    int   hs_low, bn_high, first, second, run, max_run;

    cfg[0] = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b0, 1'b0, 2};
    cfg[1] = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 0};
    cfg[2] = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0, 3};

    // {adv, en, hs, vs, sn, bn, ls, fs, nx, ny, fc} for the PIPE=0 instance
    vecs[0]  = '{0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0};
    vecs[1]  = '{0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 0};
    vecs[2]  = '{3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vecs[3]  = '{0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vecs[4]  = '{0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vecs[5]  = '{0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vecs[6]  = '{0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vecs[7]  = '{0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 0};
    vecs[8]  = '{23, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0};
    vecs[9]  = '{4,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vecs[10] = '{2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0};
    vecs[11] = '{6,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vecs[12] = '{0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1};

    rst_n  = 3'b000;
    pix_en = 3'b000;
    for (int d = 0; d < 3; d++) strobes[d] = 0;

    repeat (3) @(posedge Clock);
    @(negedge Clock);
    for (int d = 0; d < 3; d++) checkOutput("reset_state", d, 0, 1'b0);
    @(posedge Clock);
    #1;
    rst_n = 3'b111;

    // Default timing: two full lines with pixEn held high.
    for (int i = 0; i < 1040; i++) applyStimulus(0, 1'b1, "line0");
    hs_low  = 0;
    bn_high = 0;
    for (int i = 0; i < 1040; i++) begin
      pix_en[0] = 1'b1;
      @(negedge Clock);
      if (!hsync0) hs_low++;
      if (blank_n0) bn_high++;
      checkOutput("line1", 0, strobes[0], 1'b1);
      @(posedge Clock);
      strobes[0]++;
      #1;
    end
    checkValue("hsync_low_cycles", hs_low, 120);
    checkValue("blank_high_cycles", bn_high, 800);

    // Default timing: pixEn toggling, one line should take 2080 clocks.
    first = -1; second = -1; run = 0; max_run = 0;
    for (int i = 0; i < 2100; i++) begin
      pix_en[0] = (i % 2 == 0);
      @(negedge Clock);
      if (line_start0) begin
        run++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end else begin
        run = 0;
      end
      if (run > max_run) max_run = run;
      checkOutput("toggle", 0, strobes[0], pix_en[0]);
      @(posedge Clock);
      if (pix_en[0]) strobes[0]++;
      #1;
    end
    checkValue("line_period", second - first, 2080);
    checkValue("linestart_width", max_run, 1);

    // Asynchronous reset in the middle of a line at hCount=500.
    for (int i = 0; i < 2000 && (strobes[0] % 1040) != 500; i++) applyStimulus(0, 1'b1, "seek");
    checkValue("seek_h500", strobes[0] % 1040, 500);
    pix_en[0] = 1'b1;
    #1 rst_n[0] = 1'b0;
    #1 strobes[0] = 0;
    checkOutput("async_reset0", 0, 0, 1'b1);
    #1 rst_n[0] = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(0, 1'b1, "post_reset0");

    // PIPE=0, positive polarity: hand-derived vectors.
    for (int r = 0; r < 13; r++) begin
      for (int k = 0; k < vecs[r].adv; k++) applyStimulus(1, 1'b1, "advance");
      pix_en[1] = vecs[r].en;
      @(negedge Clock);
      want    = '0;
      want.hs = vecs[r].hs; want.vs = vecs[r].vs;
      want.sn = vecs[r].sn; want.bn = vecs[r].bn;
      want.ls = vecs[r].ls; want.fs = vecs[r].fs;
      want.nx = 16'(vecs[r].nx); want.ny = 16'(vecs[r].ny);
      want.fc = 8'(vecs[r].fc);
      got = sample(1);
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL vector%0d got=%h expected=%h", r, got, want);
      end
      @(posedge Clock);
      if (vecs[r].en) strobes[1]++;
      #1;
    end
    for (int i = 0; i < 1500; i++) applyStimulus(1, $urandom_range(0, 3) != 0, "random1");

    // PIPE=3: random strobes, a mid-frame reset, then 256 frames.
    for (int i = 0; i < 150; i++) applyStimulus(2, $urandom_range(0, 3) != 0, "random2");
    #1 rst_n[2] = 1'b0;
    #1 strobes[2] = 0;
    checkOutput("async_reset2", 2, 0, pix_en[2]);
    #1 rst_n[2] = 1'b1;
    fs_count = 0;
    for (int i = 0; i < 40000 && strobes[2] < 12288; i++)
      applyStimulus(2, $urandom_range(0, 3) != 0, "frames");
    checkValue("frame_strobes", strobes[2], 12288);
    checkValue("frame_starts", fs_count, 256);
    checkValue("frame_count_wrap", frame_count2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
